// File: rtl/stopwatch_game_ctrl.sv
// Stopwatch reaction game: runs a 0..CNT_LIM-1 counter, freezes it on a button
// press and judges the frozen LED position against the enable switches.
module stopwatch_game_ctrl #(
  parameter int LED_NUM  = 10,
  parameter int CNT_LIM  = 100,
  parameter int TICK_DIV = 500000,
  parameter int SCORE_W  = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       btn_i,
  input  logic [LED_NUM-1:0]         sw_i,
  output logic [$clog2(CNT_LIM):0]   cnt_o,
  output logic                       run_o,
  output logic                       hit_o,
  output logic                       miss_o,
  output logic [SCORE_W-1:0]         score_o
);

  localparam int CNT_W = $clog2(CNT_LIM) + 1;
  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IDX_W = (LED_NUM > 1) ? $clog2(LED_NUM) : 1;

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  state_t           state, state_nxt;
  logic [PRE_W-1:0] pre;
  logic             tick;
  logic [CNT_W-1:0] tens;
  logic [CNT_W-1:0] idx_full;
  logic             hit;

  assign tick = (pre == PRE_W'(TICK_DIV - 1));

  // Strip mapping: decade 0 lights LED #0, decade d>0 lights LED #(LED_NUM-d).
  always_comb begin
    tens     = cnt_o / CNT_W'(10);
    idx_full = (tens == '0) ? '0 : CNT_W'(LED_NUM) - tens;
    hit      = sw_i[idx_full[IDX_W-1:0]];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_nxt;
  end

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (btn_i) state_nxt = RUN;
      RUN:     if (btn_i) state_nxt = STOP;
      STOP:    if (btn_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pre     <= '0;
      cnt_o   <= '0;
      run_o   <= 1'b0;
      hit_o   <= 1'b0;
      miss_o  <= 1'b0;
      score_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt_o  <= '0;
          hit_o  <= 1'b0;
          miss_o <= 1'b0;
          if (btn_i) begin
            pre   <= '0;
            run_o <= 1'b1;
          end
        end
        RUN: begin
          // The button wins over a coincident tick: the count freezes as shown.
          if (btn_i) begin
            run_o  <= 1'b0;
            hit_o  <= hit;
            miss_o <= !hit;
            if (hit && (score_o != '1)) score_o <= score_o + 1'b1;
          end else if (tick) begin
            pre   <= '0;
            cnt_o <= (cnt_o == CNT_W'(CNT_LIM - 1)) ? '0 : cnt_o + 1'b1;
          end else begin
            pre <= pre + 1'b1;
          end
        end
        STOP: begin
          if (btn_i) begin
            cnt_o  <= '0;
            hit_o  <= 1'b0;
            miss_o <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/stopwatch_game_ctrl.md
Name: stopwatch_game_ctrl

Overview:
- Sequential producer of the stopwatch counter value that the LED strip decoder consumes: runs a 00..99 counter, freezes it on a button press and judges the stop position against the enabled-LED switches.
- LED mapping is the strip's own: cnt 0..9 -> LED #0; cnt 10..19 -> LED #9; 20..29 -> #8; ... 90..99 -> #1.
- Sits between the debounced button, the switch bank and the led_strip/7-segment display blocks.

Parameters:
- LED_NUM, 10, number of LEDs/switches; must equal CNT_LIM/10.
- CNT_LIM, 100, counter modulus; cnt_o counts 0..CNT_LIM-1.
- TICK_DIV, 500000, clk_i cycles per counter increment (100 Hz at 50 MHz).
- SCORE_W, 8, width of the hit score counter.

Ports:
- clk_i  input  1  system clock, all logic on rising edge.
- rst_n_i  input  1  asynchronous active-low reset.
- btn_i  input  1  single-cycle start/stop/clear pulse from the debouncer.
- sw_i  input  LED_NUM  LED enable switches, active high, sampled at the stop event.
- cnt_o  output  $clog2(CNT_LIM)+1  counter value, straight to the led_strip cnt_i.
- run_o  output  1  high while the counter is running.
- hit_o  output  1  high in STOP when the frozen LED's switch was set.
- miss_o  output  1  high in STOP when it was not set.
- score_o  output  SCORE_W  number of hits since reset.

Behaviour:
- Reset (async, rst_n_i=0): state IDLE; cnt_o=0, run_o=0, hit_o=0, miss_o=0, score_o=0, prescaler=0. Release is registered on the next clk_i edge.
- All outputs are registered. An event seen on btn_i at edge N is visible on the outputs after edge N.
- FSM states: IDLE, RUN, STOP.
- IDLE:
  - cnt_o held at 0.
  - btn_i=1 -> RUN, prescaler cleared to 0, run_o=1.
- RUN:
  - Prescaler counts 0..TICK_DIV-1. On the cycle it wraps, cnt_o increments by 1.
  - cnt_o wraps CNT_LIM-1 -> 0.
  - The first increment occurs exactly TICK_DIV cycles after entry.
  - btn_i=1 -> STOP. cnt_o freezes at its current value; a tick coinciding with btn_i is discarded, so the button wins.
  - At the same edge: run_o=0, and the judgement is registered.
- Judgement:
  - idx = 0 if cnt_o/10 == 0, else LED_NUM - cnt_o/10.
  - hit = sw_i[idx], using sw_i sampled on the btn_i edge.
  - hit_o=hit, miss_o=!hit.
  - score_o increments on hit and saturates at 2^SCORE_W-1.
- STOP:
  - cnt_o, hit_o, miss_o held; sw_i changes ignored.
  - btn_i=1 -> IDLE: cnt_o=0, hit_o=0, miss_o=0. score_o is retained.
- hit_o and miss_o are mutually exclusive and both 0 outside STOP.
- Asserting reset in any state returns immediately to the reset values, including score_o.
- No combinational path from any input to any output.

Test Plan:
- Reset/idle: TICK_DIV=4; hold rst_n_i=0, then release with no btn_i for 50 cycles -> cnt_o=0, run_o=0, hit_o=miss_o=0, score_o=0 throughout.
- Counting and wrap:
  - Pulse btn_i -> run_o=1.
  - cnt_o=1 at 4 cycles after entry, cnt_o=2 at 8 cycles.
  - After 400 cycles cnt_o=0 again (99->0 wrap), with no skipped or repeated values.
- Hit:
  - sw_i=10'b0100000000; stop when cnt_o=23 -> hit_o=1, miss_o=0, score_o=1, cnt_o stays 23 for 20 cycles.
  - Stop at cnt_o=5 -> miss_o=1, score_o unchanged.
- Boundary mapping: with sw_i='1, stop at each of cnt_o=0, 9, 10, 19, 90, 99 -> hit_o=1 every time, score_o=6. Repeat with sw_i=10'b0000000001 -> hit only for cnt 0 and 9.
- Simultaneous tick and button: btn_i asserted on a prescaler-wrap cycle while cnt_o=41 -> cnt_o freezes at 41, not 42.
- Clear, reset mid-run and saturation:
  - Pulse btn_i in STOP -> IDLE with cnt_o=0 and score retained.
  - Drop rst_n_i mid-RUN at cnt_o=57 -> all outputs 0 asynchronously, before the next clk_i edge.
  - SCORE_W=2: after 5 hits, score_o=3.
